decrypt_keysched: RTL and testbench

DECRYPT_KEYSCHED -- requirements
Module: decrypt_keysched

---
 rtl/decrypt_keysched.sv | 171 +++++++++++++++++
 tb/tb_decrypt_keysched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_keysched.sv
// DES round-key scheduler: emits K1..K16 (encrypt) or K16..K1 (decrypt)
// one key per ready/valid handshake, rotating the C/D halves in place.
module decrypt_keysched #(
  parameter int unsigned NROUNDS = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [63:0] user_key,
  input  logic        start,
  input  logic        mode,
  input  logic        ready,
  output logic [47:0] key_out,
  output logic        key_valid,
  output logic [3:0]  key_round,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CD_W   = 56;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned RK_W   = 48;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NROUNDS - 1);

  // FIPS 46-3 permuted choice tables, 1-based bit numbers
  localparam logic [5:0] PC1 [CD_W] = '{
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [5:0] PC2 [RK_W] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CD_W-1:0]     key_q, key_d;
  logic [CD_W-1:0]     cd_q, cd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [CD_W-1:0]     pc1_c;
  logic [IDX_W-1:0]    shift_idx_c;
  logic                key_valid_d, busy_d, done_d;
  logic [CNT_W-1:0]    key_round_d;
  logic                parity_unused;

  // Parity bits (FIPS bits 8, 16, ..., 64) never enter the schedule
  assign parity_unused = ^{user_key[56], user_key[48], user_key[40], user_key[32],
                           user_key[24], user_key[16], user_key[8],  user_key[0]};

  // SHIFT[i] is 1 for rounds 1, 2, 9, 16 and 2 otherwise
  function automatic logic shift_two(input logic [IDX_W-1:0] idx);
    return !(idx inside {5'd1, 5'd2, 5'd9, 5'd16});
  endfunction

  function automatic logic [HALF_W-1:0] rot28(input logic [HALF_W-1:0] x,
                                              input logic right, input logic two);
    logic [HALF_W-1:0] r;
    if (right) r = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    else       r = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rot_cd(input logic [CD_W-1:0] cd,
                                             input logic right, input logic two);
    return {rot28(cd[55:28], right, two), rot28(cd[27:0], right, two)};
  endfunction

  // PC-1 of the incoming key; captured at the start edge
  always_comb begin
    pc1_c = '0;
    for (int j = 0; j < int'(CD_W); j++) begin
      pc1_c[6'(55 - j)] = user_key[6'(64 - int'(PC1[6'(j)]))];
    end
  end

  // PC-2 straight off the C/D register
  always_comb begin
    key_out = '0;
    for (int j = 0; j < int'(RK_W); j++) begin
      key_out[6'(47 - j)] = cd_q[6'(56 - int'(PC2[6'(j)]))];
    end
  end

  // Encrypt rotates toward the next key, decrypt undoes the current key's shift
  assign shift_idx_c = mode_q ? (5'd16 - IDX_W'(cnt_q)) : (IDX_W'(cnt_q) + 5'd2);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mode_d  = mode_q;
    cd_d    = cd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          key_d   = pc1_c;
          mode_d  = mode;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cd_d    = mode_q ? key_q : rot_cd(key_q, 1'b0, 1'b0);
      end
      ST_RUN: begin
        if (ready) begin
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            cd_d  = rot_cd(cd_q, mode_q, shift_two(shift_idx_c));
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    key_valid_d = (state_d == ST_RUN);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d      = (state_d == ST_DONE);
    key_round_d = mode_d ? (LAST - cnt_d) : cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      mode_q    <= 1'b0;
      cd_q      <= '0;
      cnt_q     <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_round <= '0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      mode_q    <= mode_d;
      cd_q      <= cd_d;
      cnt_q     <= cnt_d;
      key_valid <= key_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      key_round <= key_round_d;
    end
  end

endmodule

// File: tb/tb_decrypt_keysched.sv
// Randomized bench for decrypt_keysched against a cumulative-shift DES key schedule model.
module tb_decrypt_keysched;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [63:0] user_key;
  logic        start;
  logic        mode;
  logic        ready;
  logic [47:0] key_out;
  logic        key_valid;
  logic [3:0]  key_round;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [47:0] exp_keys [16];
  logic [47:0] obs_first, obs_last;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  decrypt_keysched #(.NROUNDS(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .user_key  (user_key),
    .start     (start),
    .mode      (mode),
    .ready     (ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_round (key_round),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round key r = PC-2 of CD0 rotated left by the running total of SHIFT[1..r]
  task automatic model_keys(input logic [63:0] k);
    int s, p, src;
    s = 0;
    for (int r = 0; r < 16; r++) begin
      s += SHIFT_T[4'(r)];
      for (int j = 0; j < 48; j++) begin
        p   = PC2_T[6'(j)] - 1;
        src = (p < 28) ? (p + s) % 28 : 28 + ((p - 28 + s) % 28);
        exp_keys[4'(r)][6'(47 - j)] = k[6'(64 - PC1_T[6'(src)])];
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 64'(key_valid), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_round"}, 64'(key_round), 64'd0);
    check({tag, "_key"},   64'(key_out),   64'd0);
  endtask

  task automatic do_run(input logic [63:0] key, input logic md, input int stall_at,
                        input int stall_len, input bit rand_rdy, input bit disturb,
                        input int abort_at, input bit hold_start);
    int n, guard, stall_cnt, idx;
    model_keys(key);
    user_key = key;
    mode     = md;
    start    = 1'b1;
    ready    = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    if (disturb) begin
      user_key = ~key;
      mode     = ~md;
    end
    check("load_busy",  64'(busy),      64'd1);
    check("load_valid", 64'(key_valid), 64'd0);
    step();
    check("first_valid", 64'(key_valid), 64'd1);
    n = 0;
    guard = 0;
    stall_cnt = 0;
    while (n < 16 && guard < 300) begin
      idx = md ? 15 - n : n;
      check("valid", 64'(key_valid), 64'd1);
      check("key",   64'(key_out),   64'(exp_keys[4'(idx)]));
      check("round", 64'(key_round), 64'(idx));
      check("done_run", 64'(done), 64'd0);
      if (n == 0)  obs_first = key_out;
      if (n == 15) obs_last  = key_out;
      if (abort_at >= 0 && n == abort_at) begin
        n_rst = 1'b0;
        #2;
        check("no_async", 64'(key_valid), 64'd1);
        step();
        check_idle_zero("abort");
        n_rst = 1'b1;
        start = 1'b0;
        step();
        check_idle_zero("abort_after");
        return;
      end
      if (n == stall_at && stall_cnt < stall_len) begin
        ready = 1'b0;
        stall_cnt++;
      end else if (rand_rdy) begin
        ready = 1'($urandom_range(0, 1));
      end else begin
        ready = 1'b1;
      end
      if (disturb) begin
        start    = 1'($urandom_range(0, 1));
        user_key = {$urandom, $urandom};
        mode     = 1'($urandom_range(0, 1));
      end
      step();
      if (ready) n++;
      guard++;
    end
    check("accept_count", 64'(n), 64'd16);
    start = hold_start;
    ready = 1'($urandom_range(0, 1));
    check("done_pulse",  64'(done),      64'd1);
    check("done_valid",  64'(key_valid), 64'd0);
    check("done_busy",   64'(busy),      64'd0);
    step();
    check("idle_done",  64'(done),      64'd0);
    check("idle_valid", 64'(key_valid), 64'd0);
    check("idle_busy",  64'(busy),      64'd0);
  endtask

  initial begin
    n_rst    = 1'b0;
    start    = 1'b1;
    mode     = 1'b1;
    ready    = 1'b1;
    user_key = KAT_KEY;
    step();
    step();
    check_idle_zero("reset");
    n_rst = 1'b1;
    start = 1'b0;
    step();
    check_idle_zero("post_reset");

    // Known-answer encrypt and decrypt
    do_run(KAT_KEY, 1'b0, -1, 0, 1'b0, 1'b0, -1, 1'b0);
    check("kat_enc_first", 64'(obs_first), 64'h1B02EFFC7072);
    check("kat_enc_last",  64'(obs_last),  64'hCB3D8B0E17F5);
    do_run(KAT_KEY, 1'b1, -1, 0, 1'b0, 1'b0, -1, 1'b0);
    check("kat_dec_first", 64'(obs_first), 64'hCB3D8B0E17F5);
    check("kat_dec_last",  64'(obs_last),  64'h1B02EFFC7072);

    // Backpressure on key 3, then start/key/mode disturbance mid-run
    do_run(KAT_KEY, 1'b0, 2, 5, 1'b0, 1'b0, -1, 1'b0);
    do_run(KAT_KEY, 1'b1, 2, 5, 1'b0, 1'b1, -1, 1'b0);

    // Reset after the 7th accept, then a fresh full run
    do_run(KAT_KEY, 1'b0, -1, 0, 1'b0, 1'b0, 7, 1'b0);
    do_run(KAT_KEY, 1'b0, -1, 0, 1'b0, 1'b0, -1, 1'b0);
    check("fresh_first", 64'(obs_first), 64'h1B02EFFC7072);

    // Back-to-back with start held high
    do_run(KAT_KEY, 1'b0, -1, 0, 1'b0, 1'b0, -1, 1'b1);
    do_run({$urandom, $urandom}, 1'b1, -1, 0, 1'b0, 1'b0, -1, 1'b1);
    start = 1'b0;

    // Random keys, modes and ready patterns
    for (int i = 0; i < 8; i++) begin
      do_run({$urandom, $urandom}, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
